// File: rtl/geva_vec_pkg.sv
// geva_vec_pkg: shared vector sizes, memory opcodes and memory-unit states
package geva_vec_pkg;
  localparam int LANES = 8;
  localparam int ELEM_W = 8;
  localparam int ADDR_W = 16;
  localparam int LANE_W = $clog2(LANES);
  typedef enum logic [1:0] {
    MEM_GV = 2'b00,
    MEM_GE = 2'b01,
    MEM_CV = 2'b10,
    MEM_CE = 2'b11
  } mem_op_e;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} vmu_state_e;
endpackage

// File: rtl/vec_mem_addr_gen.sv
// vec_mem_addr_gen: lane counter with wrapping element address
module vec_mem_addr_gen
  import geva_vec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [LANE_W-1:0] last_idx,
  output logic [ADDR_W-1:0] addr,
  output logic [LANE_W-1:0] lane,
  output logic              last
);
  logic [ADDR_W-1:0] base_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q <= '0;
      lane <= '0;
    end else if (load) begin
      base_q <= base;
      lane <= '0;
    end else if (step && !last) begin
      lane <= lane + 1'b1;
    end
  end
  // The counter parks on the final lane so the address holds after the transfer
  assign addr = base_q + ADDR_W'(lane);
  assign last = lane == last_idx;
endmodule

// File: rtl/vec_mem_unit.sv
// vec_mem_unit: sequences vector/scalar loads and stores over a single-port RAM
module vec_mem_unit
  import geva_vec_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_st,
  input  logic [1:0]              mem_op,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LANES*ELEM_W-1:0] vec_wdata,
  input  logic [ELEM_W-1:0]       esc_wdata,
  output logic                    mem_rdy,
  output logic [LANES*ELEM_W-1:0] vec_rdata,
  output logic [ELEM_W-1:0]       esc_rdata,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [ELEM_W-1:0]       ram_wdata,
  output logic                    ram_we,
  output logic                    ram_re,
  input  logic [ELEM_W-1:0]       ram_rdata
);
  vmu_state_e state, state_d;
  mem_op_e op_q;
  logic [LANES*ELEM_W-1:0] vwd_q, shadow, merged;
  logic [ELEM_W-1:0] ewd_q;
  logic [LANE_W-1:0] lane, lane_q, last_idx;
  logic accept, is_load, is_vec, last, re_q;
  assign accept = mem_st && (state == IDLE || state == DONE);
  assign is_load = op_q[1];
  assign is_vec = !op_q[0];
  assign last_idx = is_vec ? LANE_W'(LANES - 1) : '0;
  vec_mem_addr_gen u_addr (
    .clk(clk),
    .rst_n(rst_n),
    .load(accept),
    .step(state == ISSUE),
    .base(base_addr),
    .last_idx(last_idx),
    .addr(ram_addr),
    .lane(lane),
    .last(last)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q <= MEM_GV;
      vwd_q <= '0;
      ewd_q <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_q <= mem_op_e'(mem_op);
        vwd_q <= vec_wdata;
        ewd_q <= esc_wdata;
      end
    end
  end
  always_comb begin
    state_d = accept ? ISSUE
            : state == ISSUE ? (last ? (is_load ? DRAIN : DONE) : ISSUE)
            : state == DRAIN ? DONE : IDLE;
  end
  assign ram_we = state == ISSUE && !is_load;
  assign ram_re = state == ISSUE && is_load;
  assign ram_wdata = is_vec ? vwd_q[int'(lane)*ELEM_W +: ELEM_W] : ewd_q;
  assign mem_rdy = state == DONE;
  // The final element arrives during DRAIN, so fold it in while publishing
  always_comb begin
    merged = shadow;
    merged[int'(lane_q)*ELEM_W +: ELEM_W] = ram_rdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      re_q <= 1'b0;
      lane_q <= '0;
      shadow <= '0;
      vec_rdata <= '0;
      esc_rdata <= '0;
    end else begin
      re_q <= ram_re;
      lane_q <= lane;
      if (re_q) shadow[int'(lane_q)*ELEM_W +: ELEM_W] <= ram_rdata;
      if (state == DRAIN && is_vec) vec_rdata <= merged;
      if (state == DRAIN && !is_vec) esc_rdata <= ram_rdata;
    end
  end
endmodule

// File: tb/tb_vec_mem_unit.sv
// tb_vec_mem_unit: table-driven checks of vec_mem_unit against a behavioural RAM
module tb_vec_mem_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_st = 1'b0;
  logic [1:0] mem_op = 2'b00;
  logic [15:0] base_addr = '0;
  logic [63:0] vec_wdata = '0;
  logic [7:0] esc_wdata = '0;
  logic mem_rdy, ram_we, ram_re;
  logic [63:0] vec_rdata;
  logic [7:0] esc_rdata, ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic [15:0] ram_addr;
  logic [7:0] mem [65536];
  int errors = 0;
  int checks = 0;

  vec_mem_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_st(mem_st), .mem_op(mem_op),
    .base_addr(base_addr), .vec_wdata(vec_wdata), .esc_wdata(esc_wdata),
    .mem_rdy(mem_rdy), .vec_rdata(vec_rdata), .esc_rdata(esc_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_re(ram_re), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] base;
    logic [63:0] vwd;
    logic [7:0]  ewd;
    logic [63:0] exp_vec;
    logic [7:0]  exp_esc;
  } vec_t;
  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int n;
    int done_k;
    bit ld;
    logic [15:0] ea;
    logic [7:0] ew;
    n = v.op[0] ? 1 : 8;
    ld = v.op[1];
    done_k = ld ? n + 2 : n + 1;
    mem_op = v.op;
    base_addr = v.base;
    vec_wdata = v.vwd;
    esc_wdata = v.ewd;
    mem_st = 1'b1;
    tick();
    mem_st = 1'b0;
    mem_op = ~v.op;
    base_addr = ~v.base;
    vec_wdata = ~v.vwd;
    esc_wdata = ~v.ewd;
    for (int k = 1; k <= done_k + 1; k++) begin
      chk($sformatf("op%b k%0d re/we/rdy", v.op, k), {61'd0, ram_re, ram_we, mem_rdy},
          {61'd0, ld && k <= n, !ld && k <= n, k == done_k});
      if (k <= n) begin
        ea = v.base + 16'(k - 1);
        chk($sformatf("op%b k%0d addr", v.op, k), 64'(ram_addr), 64'(ea));
        if (!ld) begin
          ew = v.op[0] ? v.ewd : v.vwd[(k - 1) * 8 +: 8];
          chk($sformatf("op%b k%0d wdata", v.op, k), 64'(ram_wdata), 64'(ew));
        end
      end
      if (k == done_k) begin
        chk($sformatf("op%b base%h vec_rdata", v.op, v.base), vec_rdata, v.exp_vec);
        chk($sformatf("op%b base%h esc_rdata", v.op, v.base), 64'(esc_rdata), 64'(v.exp_esc));
      end
      tick();
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, " outputs"}, {56'd0, mem_rdy, ram_we, ram_re, 5'd0}, 64'd0);
    chk({name, " ram_addr"}, 64'(ram_addr), 64'd0);
    chk({name, " ram_wdata"}, 64'(ram_wdata), 64'd0);
    chk({name, " vec_rdata"}, vec_rdata, 64'd0);
    chk({name, " esc_rdata"}, 64'(esc_rdata), 64'd0);
  endtask

  initial begin
    int writes;
    vec_t fresh;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[16'h0010 + i] = 8'(i + 1);
    mem[16'h0042] = 8'hA5;
    tbl[0] = '{2'b10, 16'h0010, 64'h0, 8'h00, 64'h0807060504030201, 8'h00};
    tbl[1] = '{2'b00, 16'hFFFE, 64'h8877665544332211, 8'h00, 64'h0807060504030201, 8'h00};
    tbl[2] = '{2'b10, 16'hFFFE, 64'h0, 8'h00, 64'h8877665544332211, 8'h00};
    tbl[3] = '{2'b11, 16'h0042, 64'h0, 8'h00, 64'h8877665544332211, 8'hA5};
    tbl[4] = '{2'b01, 16'h0043, 64'h0, 8'h3C, 64'h8877665544332211, 8'hA5};
    tbl[5] = '{2'b11, 16'h0043, 64'h0, 8'h00, 64'h8877665544332211, 8'h3C};
    tbl[6] = '{2'b11, 16'h0005, 64'h0, 8'h00, 64'h8877665544332211, 8'h88};
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) run_op(tbl[i]);
    chk("ram wrap 0xFFFF", 64'(mem[16'hFFFF]), 64'h22);
    chk("ram wrap 0x0000", 64'(mem[16'h0000]), 64'h33);
    // store scalar with mem_st held: accepted at T, T+2 and T+4
    mem_op = 2'b01;
    base_addr = 16'h0100;
    esc_wdata = 8'h5A;
    mem_st = 1'b1;
    writes = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 6) mem_st = 1'b0;
      if (ram_we) writes++;
      chk($sformatf("held st k%0d we/rdy", k), {62'd0, ram_we, mem_rdy},
          {62'd0, k == 1 || k == 3 || k == 5, k == 2 || k == 4 || k == 6});
    end
    chk("held st writes", 64'(writes), 64'd3);
    chk("held st ram", 64'(mem[16'h0100]), 64'h5A);
    // reset sampled at T+4 of a vector load
    mem_op = 2'b10;
    base_addr = 16'h0010;
    mem_st = 1'b1;
    tick();
    mem_st = 1'b0;
    tick();
    tick();
    tick();
    chk("pre-reset re", 64'(ram_re), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_zero("mid-op reset");
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("post-reset idle %0d", k), {61'd0, ram_re, ram_we, mem_rdy}, 64'd0);
      tick();
    end
    fresh = tbl[0];
    run_op(fresh);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
